// File: rtl/message_generation_unit_if.sv
// Bundle of the message generation unit's vertex input, HBM read port and update output.
// The master modport is the unit itself; the slave modport is its surroundings.
interface message_generation_unit_if #(
    parameter int VPropWidth   = 32,
    parameter int EIndexWidth  = 32,
    parameter int EDegreeWidth = 32,
    parameter int AddrWidth    = 33,
    parameter int DataWidth    = 256
);
    localparam int UpdateWidth = AddrWidth + VPropWidth;

    logic [VPropWidth+EIndexWidth+EDegreeWidth-1:0] mgu_data;
    logic                                           mgu_ready;
    logic                                           mgu_resp;
    logic [1:0]                                     control;
    logic [AddrWidth-1:0]                           read_addr;
    logic [DataWidth-1:0]                           read_data;
    logic                                           start_rd;
    logic                                           end_rd;
    logic [UpdateWidth-1:0]                         update;
    logic                                           update_ready;
    logic                                           update_resp;
    logic                                           busy;

    modport master (
        input  mgu_data, mgu_ready, control, read_data, end_rd, update_resp,
        output mgu_resp, read_addr, start_rd, update, update_ready, busy
    );

    modport slave (
        output mgu_data, mgu_ready, control, read_data, end_rd, update_resp,
        input  mgu_resp, read_addr, start_rd, update, update_ready, busy
    );
endinterface

// File: rtl/message_generation_unit.sv
// Walks an activated vertex's edge list in HBM and emits one {dest address, value} message per edge.
// Define MGU_WEIGHT_EN to let control 2'b11 (SSSP) use prop + weight; otherwise every mode uses prop + 1.
module message_generation_unit #(
    parameter int                   VPropWidth   = 32,
    parameter int                   EIndexWidth  = 32,
    parameter int                   EDegreeWidth = 32,
    parameter int                   AddrWidth    = 33,
    parameter int                   DataWidth    = 256,
    parameter logic [AddrWidth-1:0] EdgeBase     = 33'h1_0000_0000,
    parameter logic [AddrWidth-1:0] VertexBase   = 33'h0,
    parameter int                   UpdateWidth  = AddrWidth + VPropWidth
) (
    input  logic                       clk,
    input  logic                       reset,
    message_generation_unit_if.master  bus
);
    localparam int Entries = DataWidth / 64;

    typedef enum logic [2:0] {IDLE, FETCH, FETCH_WAIT, EMIT, EMIT_WAIT} state_t;

    state_t                   state_reg, state_next;
    logic [VPropWidth-1:0]    prop_reg, prop_next;
    logic [EIndexWidth-1:0]   cur_idx_reg, cur_idx_next;
    logic [EDegreeWidth-1:0]  remaining_reg, remaining_next;
    logic [1:0]               slot_reg, slot_next;
    logic [DataWidth-1:0]     word_reg, word_next;
    logic                     mgu_resp_reg, mgu_resp_next;
    logic                     start_rd_reg, start_rd_next;
    logic [AddrWidth-1:0]     read_addr_reg, read_addr_next;
    logic [UpdateWidth-1:0]   update_reg, update_next;
    logic                     update_ready_reg, update_ready_next;

    logic [VPropWidth-1:0]    in_prop;
    logic [EIndexWidth-1:0]   in_idx;
    logic [EDegreeWidth-1:0]  in_deg;
    assign in_prop = bus.mgu_data[VPropWidth+EIndexWidth+EDegreeWidth-1 -: VPropWidth];
    assign in_idx  = bus.mgu_data[EIndexWidth+EDegreeWidth-1 -: EIndexWidth];
    assign in_deg  = bus.mgu_data[EDegreeWidth-1:0];

    // Each 64-bit entry is {dest id[63:32], weight[31:0]}, entry 0 in the low bits.
    logic [31:0] dest_ids [Entries];
    genvar gi;
    generate
        for (gi = 0; gi < Entries; gi++) begin : g_entry
            assign dest_ids[gi] = word_reg[gi*64+32 +: 32];
        end
    endgenerate

`ifdef MGU_WEIGHT_EN
    logic [1:0]  control_reg, control_next;
    logic [31:0] weights [Entries];
    generate
        for (gi = 0; gi < Entries; gi++) begin : g_weight
            assign weights[gi] = word_reg[gi*64 +: 32];
        end
    endgenerate
`else
    logic [Entries-1:0] unused_weight_bits;
    logic               unused_control;
    generate
        for (gi = 0; gi < Entries; gi++) begin : g_weight_sink
            assign unused_weight_bits[gi] = ^word_reg[gi*64 +: 32];
        end
    endgenerate
    assign unused_control = ^bus.control;
`endif

    logic [AddrWidth-1:0]  fetch_addr, dest_addr;
    logic [VPropWidth:0]   sum;
    logic [VPropWidth-1:0] value;

    assign fetch_addr = EdgeBase + AddrWidth'({cur_idx_reg[EIndexWidth-1:2], 5'b0});
    assign dest_addr  = VertexBase + AddrWidth'({dest_ids[slot_reg], 5'b0});

    // The extra sum bit is the carry; any carry clamps the value to all-ones.
    always_comb begin
        sum = {1'b0, prop_reg} + (VPropWidth+1)'(1);
`ifdef MGU_WEIGHT_EN
        if (control_reg == 2'b11) begin
            sum = {1'b0, prop_reg} + (VPropWidth+1)'(weights[slot_reg]);
        end
`endif
        value = sum[VPropWidth] ? '1 : sum[VPropWidth-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg        <= IDLE;
            prop_reg         <= '0;
            cur_idx_reg      <= '0;
            remaining_reg    <= '0;
            slot_reg         <= '0;
            word_reg         <= '0;
            mgu_resp_reg     <= 1'b0;
            start_rd_reg     <= 1'b0;
            read_addr_reg    <= '0;
            update_reg       <= '0;
            update_ready_reg <= 1'b0;
`ifdef MGU_WEIGHT_EN
            control_reg      <= '0;
`endif
        end else begin
            state_reg        <= state_next;
            prop_reg         <= prop_next;
            cur_idx_reg      <= cur_idx_next;
            remaining_reg    <= remaining_next;
            slot_reg         <= slot_next;
            word_reg         <= word_next;
            mgu_resp_reg     <= mgu_resp_next;
            start_rd_reg     <= start_rd_next;
            read_addr_reg    <= read_addr_next;
            update_reg       <= update_next;
            update_ready_reg <= update_ready_next;
`ifdef MGU_WEIGHT_EN
            control_reg      <= control_next;
`endif
        end
    end

    always_comb begin
        state_next        = state_reg;
        prop_next         = prop_reg;
        cur_idx_next      = cur_idx_reg;
        remaining_next    = remaining_reg;
        slot_next         = slot_reg;
        word_next         = word_reg;
        mgu_resp_next     = 1'b0;
        start_rd_next     = 1'b0;
        read_addr_next    = read_addr_reg;
        update_next       = update_reg;
        update_ready_next = update_ready_reg;
`ifdef MGU_WEIGHT_EN
        control_next      = control_reg;
`endif
        case (state_reg)
            IDLE: begin
                // The producer still holds mgu_ready during our resp cycle; do not take it twice.
                if (bus.mgu_ready && !mgu_resp_reg) begin
                    prop_next      = in_prop;
                    cur_idx_next   = in_idx;
                    remaining_next = in_deg;
`ifdef MGU_WEIGHT_EN
                    control_next   = bus.control;
`endif
                    mgu_resp_next  = 1'b1;
                    if (in_deg != '0) begin
                        state_next = FETCH;
                    end
                end
            end
            FETCH: begin
                read_addr_next = fetch_addr;
                start_rd_next  = 1'b1;
                state_next     = FETCH_WAIT;
            end
            FETCH_WAIT: begin
                if (bus.end_rd) begin
                    word_next  = bus.read_data;
                    slot_next  = cur_idx_reg[1:0];
                    state_next = EMIT;
                end
            end
            EMIT: begin
                update_next       = {dest_addr, value};
                update_ready_next = 1'b1;
                state_next        = EMIT_WAIT;
            end
            EMIT_WAIT: begin
                if (bus.update_resp) begin
                    update_ready_next = 1'b0;
                    cur_idx_next      = cur_idx_reg + EIndexWidth'(1);
                    remaining_next    = remaining_reg - EDegreeWidth'(1);
                    if (remaining_reg == EDegreeWidth'(1)) begin
                        state_next = IDLE;
                    end else if (cur_idx_reg[1:0] == 2'b11) begin
                        state_next = FETCH;
                    end else begin
                        slot_next  = slot_reg + 2'd1;
                        state_next = EMIT;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.mgu_resp     = mgu_resp_reg;
    assign bus.start_rd     = start_rd_reg;
    assign bus.read_addr    = read_addr_reg;
    assign bus.update       = update_reg;
    assign bus.update_ready = update_ready_reg;
    assign bus.busy         = (state_reg != IDLE);
endmodule

// File: tb/tb_message_generation_unit.sv
// Randomized scoreboard bench for message_generation_unit: an edge-list model predicts reads and
// messages; an HBM responder and a message consumer check the DUT independently of the stimulus.
module tb_message_generation_unit;
    localparam logic [32:0] EDGE_BASE   = 33'h1_0000_0000;
    localparam logic [32:0] VERTEX_BASE = 33'h0;
`ifdef MGU_WEIGHT_EN
    localparam bit WEIGHT_EN = 1'b1;
`else
    localparam bit WEIGHT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    message_generation_unit_if bus ();

    message_generation_unit #(
        .EdgeBase   (EDGE_BASE),
        .VertexBase (VERTEX_BASE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int bp_len = 0;
    int force_delay = -1;

    logic [63:0] edge_mem [logic [31:0]];
    logic [32:0] exp_rd_addr [$];
    logic [31:0] exp_rd_word [$];
    logic [64:0] exp_upd [$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Edge list: explicit entries where a test sets them, otherwise a fixed hash of the index.
    function automatic logic [63:0] entry_of(input logic [31:0] e);
        if (edge_mem.exists(e)) return edge_mem[e];
        return {(e * 32'h9E37_79B1) ^ 32'h1234_5678, (e * 32'h85EB_CA6B) ^ 32'hF000_0000};
    endfunction

    function automatic logic [255:0] word_of(input logic [31:0] w);
        logic [255:0] d;
        for (int s = 0; s < 4; s++) d[s*64 +: 64] = entry_of(w * 32'd4 + 32'(s));
        return d;
    endfunction

    function automatic logic [31:0] exp_value(input logic [31:0] prop, input logic [31:0] w,
                                              input logic [1:0] ctrl);
        logic [63:0] s;
        if (WEIGHT_EN && ctrl == 2'b11) s = 64'(prop) + 64'(w);
        else                            s = 64'(prop) + 64'd1;
        if (s > 64'hFFFF_FFFF) s = 64'hFFFF_FFFF;
        return s[31:0];
    endfunction

    function automatic void model_vertex(input logic [31:0] prop, input logic [31:0] idx,
                                         input logic [31:0] deg, input logic [1:0] ctrl);
        logic [31:0] e;
        logic [63:0] ent, t;
        logic [32:0] addr;
        for (longint k = 0; k < longint'(deg); k++) begin
            e = idx + 32'(k);
            if (k == 0 || e % 4 == 0) begin
                t = 64'(EDGE_BASE) + 64'(e / 4) * 64'd32;
                exp_rd_addr.push_back(t[32:0]);
                exp_rd_word.push_back(e / 4);
            end
            ent  = entry_of(e);
            t    = 64'(VERTEX_BASE) + 64'(ent[63:32]) * 64'd32;
            addr = t[32:0];
            exp_upd.push_back({addr, exp_value(prop, ent[31:0], ctrl)});
        end
    endfunction

    // HBM model: answers each start_rd after a random (or forced) number of cycles.
    initial begin
        logic [32:0] a;
        logic [31:0] w;
        int d;
        bus.end_rd = 1'b0;
        bus.read_data = '0;
        forever begin
            @(negedge clk);
            if (!reset && bus.start_rd) begin
                if (exp_rd_addr.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_read: got addr %h, required no read", bus.read_addr);
                end else begin
                    a = exp_rd_addr.pop_front();
                    w = exp_rd_word.pop_front();
                    chk("read_addr", 128'(bus.read_addr), 128'(a));
                    d = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 3));
                    repeat (d) @(negedge clk);
                    bus.read_data = word_of(w);
                    bus.end_rd = 1'b1;
                    @(negedge clk);
                    bus.end_rd = 1'b0;
                end
            end
        end
    end

    // Message consumer: random or forced backpressure, checks order, value and stability.
    initial begin
        bit holding;
        int hold_cnt;
        logic [64:0] held, exp_msg;
        holding = 1'b0;
        hold_cnt = 0;
        held = '0;
        bus.update_resp = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                holding = 1'b0;
                bus.update_resp = 1'b0;
            end else if (bus.update_resp) begin
                bus.update_resp = 1'b0;
            end else if (bus.update_ready) begin
                if (!holding) begin
                    holding = 1'b1;
                    held = bus.update;
                    hold_cnt = (bp_len > 0) ? bp_len : int'($urandom_range(0, 2));
                end else begin
                    chk("update_stable", 128'(bus.update), 128'(held));
                end
                if (hold_cnt == 0) begin
                    if (exp_upd.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_update: got %h, required no message", bus.update);
                    end else begin
                        exp_msg = exp_upd.pop_front();
                        chk("update", 128'(bus.update), 128'(exp_msg));
                    end
                    bus.update_resp = 1'b1;
                    holding = 1'b0;
                end else begin
                    hold_cnt--;
                end
            end else if (holding) begin
                n_checks++;
                n_errors++;
                $display("FAIL update_ready_drop: got 0 before resp, required 1");
                holding = 1'b0;
            end
        end
    end

    // One-cycle pulse checks on start_rd and mgu_resp.
    initial begin
        logic prev_rd, prev_resp;
        prev_rd = 1'b0;
        prev_resp = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.start_rd && prev_rd) begin
                n_errors++;
                $display("FAIL start_rd_pulse: got 2 consecutive cycles, required 1");
            end
            if (bus.mgu_resp && prev_resp) begin
                n_errors++;
                $display("FAIL mgu_resp_pulse: got 2 consecutive cycles, required 1");
            end
            prev_rd = bus.start_rd;
            prev_resp = bus.mgu_resp;
        end
    end

    task automatic send_vertex(input logic [31:0] prop, input logic [31:0] idx,
                               input logic [31:0] deg, input logic [1:0] ctrl);
        int t;
        model_vertex(prop, idx, deg, ctrl);
        @(negedge clk);
        bus.mgu_data = {prop, idx, deg};
        bus.control = ctrl;
        bus.mgu_ready = 1'b1;
        @(negedge clk);
        chk("mgu_resp", 128'(bus.mgu_resp), 128'(1));
        chk("busy_after_accept", 128'(bus.busy), 128'(deg != 0));
        bus.mgu_ready = 1'b0;
        @(negedge clk);
        chk("mgu_resp_drop", 128'(bus.mgu_resp), 128'(0));
        chk("start_rd_first", 128'(bus.start_rd), 128'(deg != 0));
        t = 0;
        while ((bus.busy || exp_upd.size() != 0) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("vertex_done_in_time", 128'(t < 3000), 128'(1));
        chk("reads_outstanding", 128'(exp_rd_addr.size()), 128'(0));
        $display("vertex prop=%h idx=%h deg=%0d ctrl=%b done after %0d cycles", prop, idx, deg, ctrl, t);
    endtask

    initial begin
        logic [31:0] prop, idx, deg;
        bus.mgu_data = '0;
        bus.mgu_ready = 1'b0;
        bus.control = 2'b10;

        repeat (3) @(negedge clk);
        chk("rst_mgu_resp", 128'(bus.mgu_resp), 128'(0));
        chk("rst_start_rd", 128'(bus.start_rd), 128'(0));
        chk("rst_read_addr", 128'(bus.read_addr), 128'(0));
        chk("rst_update", 128'(bus.update), 128'(0));
        chk("rst_update_ready", 128'(bus.update_ready), 128'(0));
        chk("rst_busy", 128'(bus.busy), 128'(0));
        reset = 1'b0;

        // BFS, aligned: dest 7/9/11 -> addresses 224/288/352, value 6.
        edge_mem[32'd0] = {32'd7, 32'd100};
        edge_mem[32'd1] = {32'd9, 32'd200};
        edge_mem[32'd2] = {32'd11, 32'd300};
        send_vertex(32'd5, 32'd0, 32'd3, 2'b10);

        // Zero degree: accept pulse only.
        send_vertex(32'd123, 32'd40, 32'd0, 2'b10);
        repeat (3) @(negedge clk);
        chk("zero_deg_update_ready", 128'(bus.update_ready), 128'(0));
        chk("zero_deg_busy", 128'(bus.busy), 128'(0));

        // Unaligned start crossing a word boundary.
        send_vertex(32'd77, 32'd3, 32'd2, 2'b10);

        // SSSP saturation.
        edge_mem[32'd100] = {32'd5, 32'h20};
        send_vertex(32'hFFFF_FFF0, 32'd100, 32'd1, 2'b11);

        // Backpressure.
        bp_len = 10;
        send_vertex(32'd1000, 32'd8, 32'd3, 2'b11);
        bp_len = 0;

        // Reset while waiting for a read; the read answer arrives after release.
        force_delay = 4;
        model_vertex(32'd1, 32'd0, 32'd2, 2'b10);
        exp_upd.delete();
        @(negedge clk);
        bus.mgu_data = {32'd1, 32'd0, 32'd2};
        bus.control = 2'b10;
        bus.mgu_ready = 1'b1;
        @(negedge clk);
        bus.mgu_ready = 1'b0;
        @(negedge clk);
        chk("pre_reset_start_rd", 128'(bus.start_rd), 128'(1));
        #2 reset = 1'b1;
        #1;
        chk("midrst_start_rd", 128'(bus.start_rd), 128'(0));
        chk("midrst_read_addr", 128'(bus.read_addr), 128'(0));
        chk("midrst_busy", 128'(bus.busy), 128'(0));
        chk("midrst_update_ready", 128'(bus.update_ready), 128'(0));
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("late_end_rd_update_ready", 128'(bus.update_ready), 128'(0));
        chk("late_end_rd_busy", 128'(bus.busy), 128'(0));
        force_delay = -1;
        $display("reset mid-stream sequence done");

        for (int n = 0; n < 40; n++) begin
            prop = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 40)) : $urandom;
            idx  = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 8))
                                               : 32'($urandom_range(0, 64));
            deg  = 32'($urandom_range(0, 9));
            send_vertex(prop, idx, deg, 2'($urandom_range(0, 3)));
        end

        chk("updates_outstanding", 128'(exp_upd.size()), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/message_generation_unit.md
# message_generation_unit

- Sits directly downstream of the message processing unit.
- Accepts one activated vertex at a time as {new property, edge index, edge degree}.
- Reads that vertex's edge list from HBM and emits one update message per edge, {destination vertex address, candidate value}.
- Those messages feed back into the update input of the message processing unit.

## Interface
Parameters:
- VPropWidth, 32, vertex property width
- EIndexWidth, 32, edge index width
- EDegreeWidth, 32, edge degree width
- AddrWidth, 33, HBM byte address width
- DataWidth, 256, HBM word width; holds 4 edge entries of 64 bits, {dest id[63:32], weight[31:0]}
- EdgeBase, 33'h1_0000_0000, byte address of edge entry 0
- VertexBase, 33'h0, byte address of vertex 0; each vertex record is 32 bytes
- UpdateWidth, AddrWidth+VPropWidth, output message width

Ports:
- clk  in  1  single clock
- reset  in  1  asynchronous, active-high
- mgu_data  in  VPropWidth+EIndexWidth+EDegreeWidth  {prop, edge_index, edge_degree}
- mgu_ready  in  1  mgu_data valid; held until mgu_resp
- mgu_resp  out  1  one-cycle accept pulse
- control  in  2  2'b10 BFS, 2'b11 SSSP; other values treated as BFS
- read_addr  out  AddrWidth  edge word byte address
- read_data  in  DataWidth  edge word
- start_rd  out  1  one-cycle read request
- end_rd  in  1  read complete; read_data valid this cycle
- update  out  UpdateWidth  {dest vertex address, value}
- update_ready  out  1  message valid
- update_resp  in  1  consumer accepted message
- busy  out  1  high whenever state ≠ IDLE

## Operation
States: IDLE, FETCH, FETCH_WAIT, EMIT, EMIT_WAIT.

- **IDLE**
  - If mgu_ready: latch prop, index and degree into cur_idx and remaining, and latch control.
  - Pulse mgu_resp for 1 cycle.
  - Go to FETCH, or stay in IDLE if degree == 0.
- **FETCH**
  - read_addr = EdgeBase + (cur_idx >> 2) * 32.
  - start_rd = 1 for 1 cycle.
  - Go to FETCH_WAIT.
- **FETCH_WAIT**
  - On end_rd: register read_data, set slot = cur_idx[1:0], go to EMIT.
- **EMIT**
  - Take the entry at slot.
  - Dest address = VertexBase + dest_id * 32, truncated to AddrWidth.
  - Value: BFS uses prop + 1; SSSP uses prop + weight. Both saturate at all-ones.
  - Drive update and assert update_ready, then go to EMIT_WAIT.
- **EMIT_WAIT**
  - Hold update and update_ready until update_resp is sampled high.
  - Then drop update_ready, increment cur_idx and decrement remaining.
  - If remaining becomes 0: go to IDLE.
  - Else if the new cur_idx[1:0] == 0 (word exhausted): go to FETCH.
  - Else: go to EMIT with slot + 1.

Arithmetic: cur_idx wraps modulo 2^EIndexWidth.

## Timing
- Reset values: all outputs 0, state IDLE, internal registers 0.
- Reset mid-operation clears everything immediately; any outstanding read response is ignored after release.
- mgu_resp asserts the cycle after mgu_ready is sampled.
- mgu_ready is ignored outside IDLE.
- First start_rd comes 1 cycle after mgu_resp.
- First update_ready comes 2 cycles after end_rd (register, then EMIT).
- Minimum spacing between messages within one word is 2 cycles: EMIT, then EMIT_WAIT with immediate resp.
- update_ready never drops without update_resp; update is stable while update_ready is high.
- update_resp arriving while update_ready is low is ignored.
- end_rd outside FETCH_WAIT is ignored.
- start_rd and mgu_resp are never high for more than 1 consecutive cycle.

## Configuration
- MGU_WEIGHT_EN defined: control 2'b11 selects prop + weight (saturating), as above.
- MGU_WEIGHT_EN undefined:
  - weight field is ignored;
  - every control value uses prop + 1 (saturating);
  - weight logic is not synthesized.

## Test plan
- **BFS, aligned:** prop=5, index=0, degree=3, control=2'b10; entries dest 7/9/11.
  - Response: 1 read at EdgeBase; messages {VertexBase+224,6}, {VertexBase+288,6}, {VertexBase+352,6}; returns to IDLE.
- **Zero degree:** degree=0.
  - Response: mgu_resp pulse, no start_rd, no update_ready, busy low next cycle.
- **Unaligned, word crossing:** index=3, degree=2.
  - Response: reads at EdgeBase+0 then EdgeBase+32; messages use slot 3 of word 0, then slot 0 of word 1.
- **SSSP saturation (MGU_WEIGHT_EN):** control=2'b11, prop=32'hFFFF_FFF0, weight=32'h20.
  - Response: value 32'hFFFF_FFFF.
- **Backpressure:** update_resp held low for 10 cycles.
  - Response: update_ready and update stay constant; next message appears only after resp.
- **Reset mid-stream:** assert reset in FETCH_WAIT.
  - Response: all outputs 0 same cycle; a late end_rd after release produces no update.
